hyper_axi_mem_resp: RTL
=======================

HYPER_AXI_MEM_RESP -- requirements
Module: hyper_axi_mem_resp

Interface
REQ-001 SHALL have parameter AxiAddrWidth, default 32, AXI address width.
REQ-002 SHALL have parameter AxiDataWidth, default 64, AXI data width (power of 2, 8..1024).
REQ-003 SHALL have parameter AxiIdWidth, default 6, AXI ID width.
REQ-004 SHALL have parameter MemBase, default 32'h8000_0000, first byte address served.
REQ-005 SHALL have parameter MemBytes, default 4096, memory size in bytes (power of 2, multiple of AxiDataWidth/8).
REQ-006 SHALL have type parameters axi_req_t / axi_rsp_t, the AXI4 request/response structs from axi/typedef.svh.
REQ-007 SHALL have port clk_i  input  1  clock; all state updates on its rising edge.
REQ-008 SHALL have port rst_ni  input  1  reset; synchronous, active-low.
REQ-009 SHALL have port axi_req_i  input  axi_req_t  AXI4 slave request (AW, W, B ready, AR, R ready).
REQ-010 SHALL have port axi_rsp_o  output  axi_rsp_t  AXI4 slave response (AW/W/AR ready, B, R).
REQ-011 SHALL have port busy_o  output  1  high whenever FSM not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, WDATA, WRESP, RDATA; one transaction in flight at a time.
REQ-013 SHALL in IDLE assert aw_ready/ar_ready combinationally per arbitration; only one of them per cycle.
REQ-014 SHALL arbitrate round-robin when AW and AR valid together: grant the one not granted last; first after reset = write.
REQ-015 SHALL on AW handshake latch id, addr, len, size, burst and go to WDATA.
REQ-016 SHALL in WDATA hold w_ready=1, write byte lanes with w_strb=1 at current address, advance beat counter; after beat len go to WRESP.
REQ-017 SHALL flag SLVERR if w_last disagrees with beat counter on any beat; beat count governed by len, not w_last.
REQ-018 SHALL in WRESP drive b_valid=1, b_id=latched id, b_resp; hold until b_ready; then IDLE in the same cycle's next state.
REQ-019 SHALL on AR handshake go to RDATA; first r_valid on the next cycle (latency 1), then one beat per cycle while r_ready=1.
REQ-020 SHALL drive r_data stable while r_valid=1 and r_ready=0; r_last=1 on beat len; r_id=latched id.
REQ-021 SHALL increment address by 2**size per beat for INCR, aligned to size after first beat; FIXED keeps address constant.
REQ-022 SHALL answer WRAP bursts with SLVERR on every beat/B, no memory write, r_data=0.
REQ-023 SHALL compute memory index as (addr-MemBase) modulo MemBytes, word-aligned to AxiDataWidth/8; narrow beats use lanes of addr[log2(DW/8)-1:0].
REQ-024 SHALL return OKAY when no error applies; SLVERR takes priority over DECERR.
REQ-025 SHALL keep B and R responses ordered strictly in acceptance order (implied by single outstanding transaction).

Reset
REQ-026 SHALL on rst_ni=0 at rising edge: FSM=IDLE, all ready/valid outputs 0, b_resp/r_resp=OKAY, r_data=0, ids=0, round-robin pointer=write, busy_o=0.
REQ-027 SHALL abort an in-flight burst on reset mid-operation without emitting its remaining beats or B; memory content not cleared.

Configuration
REQ-028 SHALL honour macro HYPER_AXI_MEM_RESP_OOR_ERR_EN: defined -> any beat with address outside [MemBase, MemBase+MemBytes) gets DECERR, write discarded, read data 0; undefined -> out-of-range addresses alias modulo MemBytes with OKAY.

Verification
REQ-029 SHALL cover: AW addr 0x8000_0000 len 3 size 3 INCR, data 0x11..0x44, strb 0xFF -> B OKAY; AR same -> 4 beats 0x11,0x22,0x33,0x44, r_last on beat 4, first r_valid 1 cycle after AR handshake.
REQ-030 SHALL cover: AW/AR valid same cycle twice after reset -> write granted first, read second, then alternating.
REQ-031 SHALL cover: narrow write size 0 addr 0x8000_0003 data lane3=0xAB strb 0x08 -> read 64-bit word shows 0xAB in byte 3, other bytes unchanged.
REQ-032 SHALL cover: r_ready held 0 for 5 cycles mid-burst -> r_data/r_last/r_id stable, no beat lost.
REQ-033 SHALL cover: write len 1 with w_last on beat 0 -> 2 beats consumed, B SLVERR; WRAP read -> all beats SLVERR, data 0.
REQ-034 SHALL cover: read addr 0x8000_1000 with MemBytes 4096 -> DECERR/data 0 with macro defined, OKAY/data of 0x8000_0000 without.

Source files
------------

// File: rtl/hyper_axi_mem_resp.sv
// hyper_axi_mem_resp: single-outstanding AXI4 slave backed by an on-chip byte-lane memory.
// Optional feature macro: HYPER_AXI_MEM_RESP_OOR_ERR_EN
//   defined   -> beats addressed outside [MemBase, MemBase+MemBytes) answer DECERR,
//                writes are dropped and read data is zero.
//   undefined -> out-of-range addresses alias modulo MemBytes and answer OKAY.

package hyper_axi_mem_resp_pkg;

    // Default AXI4 channel layout: 32-bit address, 64-bit data, 6-bit ID.
    typedef struct packed {
        logic [5:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
    } ax_chan_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } w_chan_t;

    typedef struct packed {
        logic [5:0] id;
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [5:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } axi_rsp_t;

endpackage

module hyper_axi_mem_resp #(
    parameter int unsigned                AxiAddrWidth = 32,
    parameter int unsigned                AxiDataWidth = 64,
    parameter int unsigned                AxiIdWidth   = 6,
    parameter logic [AxiAddrWidth-1:0]    MemBase      = 32'h8000_0000,
    parameter int unsigned                MemBytes     = 4096,
    parameter type                        axi_req_t    = hyper_axi_mem_resp_pkg::axi_req_t,
    parameter type                        axi_rsp_t    = hyper_axi_mem_resp_pkg::axi_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  axi_req_t axi_req_i,
    output axi_rsp_t axi_rsp_o,
    output logic     busy_o
);

    localparam int unsigned StrbWidth = AxiDataWidth / 8;
    localparam int unsigned LaneBits  = $clog2(StrbWidth);
    localparam int unsigned Words     = MemBytes / StrbWidth;
    localparam int unsigned MemBits   = $clog2(MemBytes);

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstWrap  = 2'b10;
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_e;

    state_e                    state_reg, state_next;
    logic [AxiIdWidth-1:0]     id_reg;
    logic [AxiAddrWidth-1:0]   addr_reg;
    logic [7:0]                len_reg;
    logic [2:0]                size_reg;
    logic [1:0]                burst_reg;
    logic [7:0]                beat_reg;
    logic                      slverr_reg;
    logic                      decerr_reg;
    logic                      prefer_wr_reg;
    logic                      r_valid_reg;
    logic                      r_last_reg;
    logic [1:0]                r_resp_reg;
    logic [AxiDataWidth-1:0]   r_data;

    logic                      grant_aw, grant_ar;
    logic                      w_beat, r_beat, beat_err_w, mem_we;
    logic                      rd_en, rd_zero, r_last_next;
    logic [AxiAddrWidth-1:0]   rd_addr, addr_adv, wr_offset, rd_offset;
    logic [1:0]                rd_burst, rd_resp, b_resp;
    logic                      wr_oor, rd_oor;
    logic [MemBits-LaneBits-1:0] wr_idx, rd_idx;

    // Address of the following beat: FIXED stays put, INCR/WRAP step from the size-aligned address.
    function automatic logic [AxiAddrWidth-1:0] next_addr(input logic [AxiAddrWidth-1:0] addr,
                                                           input logic [2:0]              size,
                                                           input logic [1:0]              burst);
        logic [AxiAddrWidth-1:0] step;
        step = AxiAddrWidth'(1) << size;
        if (burst == BurstFixed) begin
            next_addr = addr;
        end else begin
            next_addr = (addr & ~(step - AxiAddrWidth'(1))) + step;
        end
    endfunction

    assign w_beat     = (state_reg == WDATA) && axi_req_i.w_valid;
    assign r_beat     = (state_reg == RDATA) && r_valid_reg && axi_req_i.r_ready;
    assign addr_adv   = next_addr(addr_reg, size_reg, burst_reg);
    assign beat_err_w = axi_req_i.w.last != (beat_reg == len_reg);

    // Memory is indexed by the offset from MemBase, wrapped to the memory size.
    assign wr_offset = addr_reg - MemBase;
    assign rd_offset = rd_addr - MemBase;
    assign wr_idx    = wr_offset[MemBits-1:LaneBits];
    assign rd_idx    = rd_offset[MemBits-1:LaneBits];

`ifdef HYPER_AXI_MEM_RESP_OOR_ERR_EN
    assign wr_oor = wr_offset >= AxiAddrWidth'(MemBytes);
    assign rd_oor = rd_offset >= AxiAddrWidth'(MemBytes);
`else
    assign wr_oor = 1'b0;
    assign rd_oor = 1'b0;
`endif

    assign mem_we  = w_beat && (burst_reg != BurstWrap) && !wr_oor;
    assign rd_zero = (rd_burst == BurstWrap) || rd_oor;
    assign rd_resp = (rd_burst == BurstWrap) ? RespSlvErr : (rd_oor ? RespDecErr : RespOkay);
    assign b_resp  = ((burst_reg == BurstWrap) || slverr_reg) ? RespSlvErr :
                     (decerr_reg ? RespDecErr : RespOkay);
    assign busy_o  = state_reg != IDLE;

    // Next state, round-robin address-channel grant and read-port request.
    always_comb begin
        state_next  = state_reg;
        grant_aw    = 1'b0;
        grant_ar    = 1'b0;
        rd_en       = 1'b0;
        rd_addr     = addr_adv;
        rd_burst    = burst_reg;
        r_last_next = (beat_reg + 8'd1) == len_reg;
        case (state_reg)
            IDLE: begin
                if (rst_ni) begin
                    if (axi_req_i.aw_valid && (!axi_req_i.ar_valid || prefer_wr_reg)) begin
                        grant_aw = 1'b1;
                    end else if (axi_req_i.ar_valid) begin
                        grant_ar = 1'b1;
                    end
                end
                if (grant_aw) begin
                    state_next = WDATA;
                end else if (grant_ar) begin
                    state_next  = RDATA;
                    rd_en       = 1'b1;
                    rd_addr     = axi_req_i.ar.addr;
                    rd_burst    = axi_req_i.ar.burst;
                    r_last_next = axi_req_i.ar.len == 8'd0;
                end
            end
            WDATA: begin
                if (axi_req_i.w_valid && (beat_reg == len_reg)) begin
                    state_next = WRESP;
                end
            end
            WRESP: begin
                if (axi_req_i.b_ready) begin
                    state_next = IDLE;
                end
            end
            RDATA: begin
                if (r_beat) begin
                    if (r_last_reg) begin
                        state_next = IDLE;
                    end else begin
                        rd_en = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Burst context, beat counting, error flags and R-channel control.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            id_reg        <= '0;
            addr_reg      <= '0;
            len_reg       <= '0;
            size_reg      <= '0;
            burst_reg     <= '0;
            beat_reg      <= '0;
            slverr_reg    <= 1'b0;
            decerr_reg    <= 1'b0;
            prefer_wr_reg <= 1'b1;
            r_valid_reg   <= 1'b0;
            r_last_reg    <= 1'b0;
            r_resp_reg    <= RespOkay;
        end else begin
            if (grant_aw) begin
                id_reg        <= axi_req_i.aw.id;
                addr_reg      <= axi_req_i.aw.addr;
                len_reg       <= axi_req_i.aw.len;
                size_reg      <= axi_req_i.aw.size;
                burst_reg     <= axi_req_i.aw.burst;
                beat_reg      <= '0;
                slverr_reg    <= 1'b0;
                decerr_reg    <= 1'b0;
                prefer_wr_reg <= 1'b0;
            end else if (grant_ar) begin
                id_reg        <= axi_req_i.ar.id;
                addr_reg      <= axi_req_i.ar.addr;
                len_reg       <= axi_req_i.ar.len;
                size_reg      <= axi_req_i.ar.size;
                burst_reg     <= axi_req_i.ar.burst;
                beat_reg      <= '0;
                prefer_wr_reg <= 1'b1;
            end else if (w_beat) begin
                beat_reg <= beat_reg + 8'd1;
                addr_reg <= addr_adv;
                if (beat_err_w) begin
                    slverr_reg <= 1'b1;
                end
                if (wr_oor) begin
                    decerr_reg <= 1'b1;
                end
            end else if (r_beat) begin
                beat_reg <= beat_reg + 8'd1;
                addr_reg <= addr_adv;
            end

            if (rd_en) begin
                r_valid_reg <= 1'b1;
                r_last_reg  <= r_last_next;
                r_resp_reg  <= rd_resp;
            end else if (r_beat) begin
                r_valid_reg <= 1'b0;
            end
        end
    end

    // One byte-wide memory per lane so each strobe bit is a plain write enable.
    for (genvar gi = 0; gi < StrbWidth; gi++) begin : g_lane
        logic [7:0] lane_mem [Words];
        logic [7:0] rd_byte_reg;

        // Byte-lane write; contents survive reset.
        always_ff @(posedge clk_i) begin
            if (mem_we && axi_req_i.w.strb[gi]) begin
                lane_mem[wr_idx] <= axi_req_i.w.data[gi*8 +: 8];
            end
        end

        // Registered read; holds while the master stalls, zero for error beats.
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                rd_byte_reg <= '0;
            end else if (rd_en) begin
                rd_byte_reg <= rd_zero ? 8'h00 : lane_mem[rd_idx];
            end
        end

        assign r_data[gi*8 +: 8] = rd_byte_reg;
    end

    // Response channels.
    always_comb begin
        axi_rsp_o          = '0;
        axi_rsp_o.aw_ready = grant_aw;
        axi_rsp_o.ar_ready = grant_ar;
        axi_rsp_o.w_ready  = state_reg == WDATA;
        axi_rsp_o.b_valid  = state_reg == WRESP;
        axi_rsp_o.b.id     = id_reg;
        axi_rsp_o.b.resp   = b_resp;
        axi_rsp_o.r_valid  = r_valid_reg;
        axi_rsp_o.r.id     = id_reg;
        axi_rsp_o.r.data   = r_data;
        axi_rsp_o.r.resp   = r_resp_reg;
        axi_rsp_o.r.last   = r_last_reg;
    end

    // Request fields this slave does not interpret, plus offset bits outside the index.
    logic unused_bits;
    assign unused_bits = ^{axi_req_i.aw.lock, axi_req_i.aw.cache, axi_req_i.aw.prot, axi_req_i.aw.qos,
                           axi_req_i.ar.lock, axi_req_i.ar.cache, axi_req_i.ar.prot, axi_req_i.ar.qos,
                           wr_offset, rd_offset};

endmodule
